np_gpio: RTL
============

NP_GPIO -- requirements
Module: np_gpio

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of GPIO pins (1..32).
REQ-002 SHALL have parameter BASE_SEL, default 8'h03, matched against iomem_addr[31:24].
REQ-003 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth (2..4).
REQ-004 CLK  in  1  single clock; all logic on rising edge.
REQ-005 RST  in  1  asynchronous, active-low reset.
REQ-006 iomem_valid  in  1  bus request.
REQ-007 iomem_ready  out  1  one-cycle acknowledge.
REQ-008 iomem_wstrb  in  4  byte write strobes; 0 = read.
REQ-009 iomem_addr  in  32  byte address.
REQ-010 iomem_wdata  in  32  write data.
REQ-011 iomem_rdata  out  32  read data, valid while iomem_ready=1.
REQ-012 gpio_in  in  WIDTH  asynchronous pin inputs.
REQ-013 gpio_out  out  WIDTH  output data register.
REQ-014 gpio_oe  out  WIDTH  per-pin output enable (1 = drive).
REQ-015 irq  out  1  level interrupt, registered.

Function
REQ-016 Select SHALL be iomem_valid & !iomem_ready & addr[31:24]==BASE_SEL & addr[23:5]==0; register offset = addr[4:2].
REQ-017 Map: 0 OUT (rw), 1 OE (rw), 2 IN (ro, synchronized pins), 3 IRQ_EN (rw), 4 IRQ_POL (rw, 1=rising, 0=falling), 5 IRQ_PEND (read; write-1-to-clear); offsets 6-7 read 0, writes ignored.
REQ-018 On select, iomem_ready SHALL assert on the next edge for exactly one cycle; iomem_rdata SHALL be updated on that same edge; back-to-back requests therefore take two cycles each.
REQ-019 Writes SHALL honour each iomem_wstrb byte independently; bits at or above WIDTH SHALL be ignored on write and read as 0.
REQ-020 Writes to IN SHALL be ignored; reads of a register written in the same access SHALL return the pre-write value.
REQ-021 gpio_in SHALL pass through a SYNC_STAGES flop chain; IN reflects the last stage (latency SYNC_STAGES cycles).
REQ-022 Edge event per bit SHALL be computed from the last sync stage vs. a one-cycle-delayed copy, polarity per IRQ_POL.
REQ-023 An event SHALL set its IRQ_PEND bit regardless of IRQ_EN.
REQ-024 Event and W1C on the same bit in the same cycle: set SHALL win.
REQ-025 irq SHALL be registered |(IRQ_PEND & IRQ_EN), one cycle after pend/enable change.
REQ-026 Arm counter: edge detection SHALL be disabled until SYNC_STAGES+1 cycles after RST deasserts, so static pin levels never produce a pending bit at boot.
REQ-027 Requests outside the window SHALL leave iomem_ready and iomem_rdata unchanged (deasserted ready).

Reset
REQ-028 RST low SHALL asynchronously clear OUT, OE, IRQ_EN, IRQ_POL, IRQ_PEND, sync chain, delayed copy, arm counter, iomem_ready, iomem_rdata and irq to 0.
REQ-029 Reset mid-transaction SHALL abort it with no register updated and no ready issued after release for that request unless iomem_valid is still high.

Structure
REQ-030 Register offsets (0..5) and default BASE_SEL SHALL live in the shared package/include np_pkg, used by np_gpio and firmware headers.
REQ-031 Synchronizer SHALL be sub-module np_sync (parameters WIDTH, STAGES, async active-low reset to 0).
REQ-032 np_top SHALL instantiate np_gpio with WIDTH=8, gpio_out driving LED.

Verification
REQ-033 Write 0x000000A5 wstrb 4'hF to 0x03000000 -> ready one cycle later for one cycle; gpio_out=8'hA5; read back 0x000000A5.
REQ-034 Write 0xFFFFFF3C wstrb 4'h1 to 0x03000004 -> gpio_oe=8'h3C; read returns 0x0000003C.
REQ-035 IRQ_POL=0x01, IRQ_EN=0x01, drive gpio_in[0] 0->1 -> IRQ_PEND=0x01 after SYNC_STAGES+1 cycles, irq high one cycle later; write 0x01 to 0x03000014 -> pend and irq clear.
REQ-036 gpio_in=8'hFF held through reset release -> IRQ_PEND stays 0 and irq low for 100 cycles.
REQ-037 W1C of bit 0 coincident with a new rising edge on bit 0 -> IRQ_PEND[0] remains 1.
REQ-038 Assert RST low for 1 cycle while OUT=0x5A and a read is pending -> all outputs 0 immediately, no ready pulse, OUT reads 0 afterwards.

Source files
------------

// File: rtl/np_pkg.sv
// np_pkg: shared GPIO register map, default bus select and helpers.
// Imported by the RTL; offsets mirror the firmware header.
package np_pkg;

  localparam logic [7:0] DEF_BASE_SEL = 8'h03;

  typedef enum logic [2:0] {
    REG_OUT  = 3'd0,
    REG_OE   = 3'd1,
    REG_IN   = 3'd2,
    REG_EN   = 3'd3,
    REG_POL  = 3'd4,
    REG_PEND = 3'd5
  } reg_off_e;

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

endpackage

// File: rtl/np_sync.sv
// np_sync: multi-flop synchronizer for asynchronous pin inputs.
// Chain resets to 0; q is the last stage.
module np_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/np_top.sv
// np_top: board wrapper, 8-pin GPIO with the output register on the LEDs.
// Bus and pins are passed straight through.
module np_top
  import np_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  led,
  output logic [7:0]  gpio_oe,
  output logic        irq
);

  np_gpio #(.WIDTH(8), .BASE_SEL(DEF_BASE_SEL)) u_gpio (
    .clk         (clk),
    .rst_n       (rst_n),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .gpio_in     (gpio_in),
    .gpio_out    (led),
    .gpio_oe     (gpio_oe),
    .irq         (irq)
  );

endmodule

// File: rtl/np_gpio.sv
// np_gpio: memory-mapped GPIO with edge interrupts on an iomem bus.
// Single-cycle acknowledge; reads return the pre-write value.
module np_gpio
  import np_pkg::*;
#(
  parameter int         WIDTH       = 8,
  parameter logic [7:0] BASE_SEL    = DEF_BASE_SEL,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [2:0] ARM = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] pins, pins_d;
  logic [WIDTH-1:0] irq_en, irq_pol, irq_pend;
  logic [WIDTH-1:0] wd, wm, rv, ev, w1c;
  logic [31:0]      smask;
  logic [2:0]       arm_cnt;
  logic             armed, sel, we;
  reg_off_e         off;
  logic             unused;

  np_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gpio_in),
    .q     (pins)
  );

  assign sel = iomem_valid && !iomem_ready
            && iomem_addr[31:24] == BASE_SEL
            && iomem_addr[23:5] == '0;
  assign off   = reg_off_e'(iomem_addr[4:2]);
  assign we    = sel && |iomem_wstrb;
  assign smask = strb_mask(iomem_wstrb);
  assign wm    = smask[WIDTH-1:0];
  assign wd    = iomem_wdata[WIDTH-1:0];
  assign armed = arm_cnt == ARM;
  assign unused = &{1'b0, iomem_addr[1:0], iomem_wdata, smask};

  always_comb begin
    rv = '0;
    case (off)
      REG_OUT:  rv = gpio_out;
      REG_OE:   rv = gpio_oe;
      REG_IN:   rv = pins;
      REG_EN:   rv = irq_en;
      REG_POL:  rv = irq_pol;
      REG_PEND: rv = irq_pend;
      default:  rv = '0;
    endcase
  end

  // Edges are masked until the chain and delayed copy hold real pin data.
  always_comb begin
    ev  = '0;
    w1c = '0;
    if (armed)
      ev = (irq_pol & pins & ~pins_d) | (~irq_pol & ~pins & pins_d);
    if (we && off == REG_PEND) w1c = wd & wm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_out    <= '0;
      gpio_oe     <= '0;
      irq_en      <= '0;
      irq_pol     <= '0;
      irq_pend    <= '0;
      pins_d      <= '0;
      arm_cnt     <= '0;
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      irq         <= 1'b0;
    end else begin
      pins_d      <= pins;
      iomem_ready <= sel;
      if (!armed) arm_cnt <= arm_cnt + 3'd1;
      if (sel) iomem_rdata <= 32'(rv);
      if (we) begin
        case (off)
          REG_OUT: gpio_out <= (gpio_out & ~wm) | (wd & wm);
          REG_OE:  gpio_oe  <= (gpio_oe & ~wm) | (wd & wm);
          REG_EN:  irq_en   <= (irq_en & ~wm) | (wd & wm);
          REG_POL: irq_pol  <= (irq_pol & ~wm) | (wd & wm);
          default: ;
        endcase
      end
      irq_pend <= (irq_pend & ~w1c) | ev;
      irq      <= |(irq_pend & irq_en);
    end
  end

endmodule
